// File: rtl/fifo_ctrl_flex_if.sv
// rtl/fifo_ctrl_flex_if.sv - request/accept/status bundle for the flexible FIFO pointer controller
interface fifo_ctrl_flex_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  clr;
    logic                  rd;
    logic                  wr;
    logic                  rd_ok;
    logic                  wr_ok;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clr, rd, wr,
        input  rd_ok, wr_ok, w_addr, r_addr, count,
        input  empty, full, almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  clr, rd, wr,
        output rd_ok, wr_ok, w_addr, r_addr, count,
        output empty, full, almost_empty, almost_full, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl_flex.sv
// rtl/fifo_ctrl_flex.sv - FIFO pointer/status controller for any depth up to 2**ADDR_WIDTH
module fifo_ctrl_flex #(
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter int AF_THRESH  = DEPTH-1,
    parameter int AE_THRESH  = 1
) (
    input  logic             clk,
    input  logic             reset,
    fifo_ctrl_flex_if.slave  bus
);
    localparam int CNT_W = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      AF_LEVEL  = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0]      AE_LEVEL  = CNT_W'(AE_THRESH);

    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  ovf;
    logic                  unf;

    logic empty_q;
    logic full_q;
    logic rd_acc;
    logic wr_acc;

    // Explicit wrap at DEPTH-1 keeps non-power-of-two FIFOs inside the RAM.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        ptr_inc = (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty_q = (cnt == '0);
    assign full_q  = (cnt == FULL_CNT);

    assign rd_acc = bus.rd & ~empty_q & ~bus.clr;
    assign wr_acc = bus.wr & ~bus.clr & (~full_q | rd_acc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (bus.clr) begin
            w_ptr <= '0;
            r_ptr <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (wr_acc) begin
                w_ptr <= ptr_inc(w_ptr);
            end
            if (rd_acc) begin
                r_ptr <= ptr_inc(r_ptr);
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (bus.wr && !wr_acc) begin
                ovf <= 1'b1;
            end
            if (bus.rd && !rd_acc) begin
                unf <= 1'b1;
            end
        end
    end

    // Status flags decode only the registered count; no path from rd/wr.
    assign bus.rd_ok        = rd_acc;
    assign bus.wr_ok        = wr_acc;
    assign bus.w_addr       = w_ptr;
    assign bus.r_addr       = r_ptr;
    assign bus.count        = cnt;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = (cnt <= AE_LEVEL);
    assign bus.almost_full  = (cnt >= AF_LEVEL);
    assign bus.overflow     = ovf;
    assign bus.underflow    = unf;
endmodule

// File: tb/tb_fifo_ctrl_flex.sv
// tb/tb_fifo_ctrl_flex.sv - directed self-checking bench for fifo_ctrl_flex (DEPTH 5 and DEPTH 8)
module tb_fifo_ctrl_flex;
    logic clk;
    logic reset;

    int n_pass;
    int n_total;

    fifo_ctrl_flex_if #(.ADDR_WIDTH(3)) ba ();
    fifo_ctrl_flex_if #(.ADDR_WIDTH(3)) bb ();

    fifo_ctrl_flex #(
        .ADDR_WIDTH(3),
        .DEPTH     (5),
        .AF_THRESH (4),
        .AE_THRESH (1)
    ) dut5 (
        .clk  (clk),
        .reset(reset),
        .bus  (ba)
    );

    fifo_ctrl_flex #(
        .ADDR_WIDTH(3)
    ) dut8 (
        .clk  (clk),
        .reset(reset),
        .bus  (bb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        ba.clr = 1'b0; ba.rd = 1'b0; ba.wr = 1'b0;
        bb.clr = 1'b0; bb.rd = 1'b0; bb.wr = 1'b0;
        tick();

        check("rst_w_addr", ba.w_addr, 0);
        check("rst_r_addr", ba.r_addr, 0);
        check("rst_count", ba.count, 0);
        check("rst_empty", ba.empty, 1);
        check("rst_full", ba.full, 0);
        check("rst_ae", ba.almost_empty, 1);
        check("rst_af", ba.almost_full, 0);
        check("rst_ovf", ba.overflow, 0);
        check("rst_unf", ba.underflow, 0);
        reset = 1'b0;
        tick();

        // fill DEPTH=5, then one rejected write
        for (int i = 0; i < 5; i++) begin
            ba.wr = 1'b1;
            #1;
            check("fill_w_addr", ba.w_addr, i);
            check("fill_wr_ok", ba.wr_ok, 1);
            tick();
        end
        check("fill_full", ba.full, 1);
        check("fill_count", ba.count, 5);
        check("fill_w_wrap", ba.w_addr, 0);
        check("fill_af", ba.almost_full, 1);
        check("fill_ovf0", ba.overflow, 0);
        #1;
        check("ovf_wr_ok", ba.wr_ok, 0);
        tick();
        ba.wr = 1'b0;
        check("ovf_set", ba.overflow, 1);
        check("ovf_w_addr", ba.w_addr, 0);
        check("ovf_count", ba.count, 5);

        // simultaneous rd+wr while full
        ba.rd = 1'b1;
        ba.wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fullrw_rd_ok", ba.rd_ok, 1);
            check("fullrw_wr_ok", ba.wr_ok, 1);
            tick();
            check("fullrw_count", ba.count, 5);
            check("fullrw_full", ba.full, 1);
        end
        ba.rd = 1'b0;
        ba.wr = 1'b0;
        check("fullrw_r_addr", ba.r_addr, 3);
        check("fullrw_w_addr", ba.w_addr, 3);

        // two reads: r_addr 3 -> 4 -> 0
        ba.rd = 1'b1;
        tick();
        tick();
        ba.rd = 1'b0;
        check("drain_count", ba.count, 3);
        check("drain_r_wrap", ba.r_addr, 0);
        check("drain_ovf_sticky", ba.overflow, 1);

        // clr beats rd and wr
        ba.clr = 1'b1; ba.rd = 1'b1; ba.wr = 1'b1;
        #1;
        check("clr_rd_ok", ba.rd_ok, 0);
        check("clr_wr_ok", ba.wr_ok, 0);
        tick();
        ba.clr = 1'b0; ba.rd = 1'b0; ba.wr = 1'b0;
        check("clr_count", ba.count, 0);
        check("clr_w_addr", ba.w_addr, 0);
        check("clr_r_addr", ba.r_addr, 0);
        check("clr_ovf", ba.overflow, 0);
        check("clr_empty", ba.empty, 1);

        // rd+wr on empty: only write accepted
        ba.rd = 1'b1; ba.wr = 1'b1;
        #1;
        check("emptyrw_wr_ok", ba.wr_ok, 1);
        check("emptyrw_rd_ok", ba.rd_ok, 0);
        tick();
        ba.wr = 1'b0;
        check("emptyrw_unf", ba.underflow, 1);
        check("emptyrw_count", ba.count, 1);
        check("emptyrw_r_addr", ba.r_addr, 0);
        check("emptyrw_empty", ba.empty, 0);
        #1;
        check("rd1_rd_ok", ba.rd_ok, 1);
        check("rd1_r_addr", ba.r_addr, 0);
        tick();
        check("rd1_count", ba.count, 0);
        check("rd1_empty", ba.empty, 1);
        check("rd1_r_addr_next", ba.r_addr, 1);

        // rejected read changes nothing else
        tick();
        ba.rd = 1'b0;
        check("rej_r_addr", ba.r_addr, 1);
        check("rej_count", ba.count, 0);
        check("rej_unf", ba.underflow, 1);

        // thresholds AF=4, AE=1 over count 0..5..0
        ba.clr = 1'b1;
        tick();
        ba.clr = 1'b0;
        check("clr2_unf", ba.underflow, 0);
        for (int c = 0; c <= 5; c++) begin
            check("up_count", ba.count, c);
            check("up_ae", ba.almost_empty, (c <= 1) ? 1 : 0);
            check("up_af", ba.almost_full, (c >= 4) ? 1 : 0);
            if (c < 5) begin
                ba.wr = 1'b1;
                tick();
                ba.wr = 1'b0;
            end
        end
        for (int c = 5; c >= 0; c--) begin
            check("dn_count", ba.count, c);
            check("dn_ae", ba.almost_empty, (c <= 1) ? 1 : 0);
            check("dn_af", ba.almost_full, (c >= 4) ? 1 : 0);
            if (c > 0) begin
                ba.rd = 1'b1;
                tick();
                ba.rd = 1'b0;
            end
        end

        // DEPTH=8 natural modulo wrap
        bb.wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("d8_w_addr", bb.w_addr, i);
            tick();
        end
        bb.wr = 1'b0;
        check("d8_full", bb.full, 1);
        check("d8_count", bb.count, 8);
        check("d8_w_wrap", bb.w_addr, 0);
        bb.rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("d8_r_addr", bb.r_addr, i);
            tick();
        end
        bb.rd = 1'b0;
        check("d8_empty", bb.empty, 1);
        check("d8_r_wrap", bb.r_addr, 0);

        // asynchronous reset mid-burst
        ba.wr = 1'b1;
        tick();
        tick();
        check("burst_count", ba.count, 2);
        #2;
        reset = 1'b1;
        #1;
        check("areset_count", ba.count, 0);
        check("areset_w_addr", ba.w_addr, 0);
        check("areset_empty", ba.empty, 1);
        check("areset_ae", ba.almost_empty, 1);
        ba.wr = 1'b0;
        #1;
        reset = 1'b0;
        ba.wr = 1'b1;
        tick();
        ba.wr = 1'b0;
        check("post_w_addr", ba.w_addr, 1);
        check("post_count", ba.count, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
